// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back select, r0 suppression, retire counter.
// Optional WB_HISTORY_EN adds a second (older) write-back register set.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid2,
  input  logic              RegWrite2,
  input  logic              MemtoReg2,
  input  logic              Link2,
  input  logic [REG_AW-1:0] WriteReg2,
  input  logic [DATA_W-1:0] ALUResult_out,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] PCPlus8_2,
  output logic              RegWrite3,
  output logic [REG_AW-1:0] WriteReg3,
  output logic [DATA_W-1:0] WriteData3,
  output logic              Valid3,
  output logic [31:0]       InstRetired
`ifdef WB_HISTORY_EN
  ,
  output logic              RegWrite4,
  output logic [REG_AW-1:0] WriteReg4,
  output logic [DATA_W-1:0] WriteData4
`endif
);

  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  // Link has priority over load data
  always_comb begin
    wb_data = ALUResult_out;
    if (Link2)
      wb_data = PCPlus8_2;
    else if (MemtoReg2)
      wb_data = ReadData;
  end

  assign wb_we = RegWrite2 & Valid2 & (WriteReg2 != '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Valid3     <= 1'b0;
      RegWrite3  <= 1'b0;
      WriteReg3  <= '0;
      WriteData3 <= '0;
    end else if (Flush) begin
      Valid3     <= 1'b0;
      RegWrite3  <= 1'b0;
      WriteReg3  <= '0;
      WriteData3 <= '0;
    end else if (!Stall) begin
      Valid3     <= Valid2;
      RegWrite3  <= wb_we;
      WriteReg3  <= WriteReg2;
      WriteData3 <= wb_data;
    end
  end

  // An instruction retires when it leaves the WB slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      InstRetired <= '0;
    else if (Valid3 && !Stall)
      InstRetired <= InstRetired + 32'd1;
  end

`ifdef WB_HISTORY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite4  <= 1'b0;
      WriteReg4  <= '0;
      WriteData4 <= '0;
    end else if (!Stall) begin
      RegWrite4  <= RegWrite3;
      WriteReg4  <= WriteReg3;
      WriteData4 <= WriteData3;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage with a spec-level reference model.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall, Flush, Valid2, RegWrite2, MemtoReg2, Link2;
  logic [4:0]  WriteReg2;
  logic [31:0] ALUResult_out, ReadData, PCPlus8_2;
  logic        RegWrite3, Valid3;
  logic [4:0]  WriteReg3;
  logic [31:0] WriteData3, InstRetired;
`ifdef WB_HISTORY_EN
  logic        RegWrite4;
  logic [4:0]  WriteReg4;
  logic [31:0] WriteData4;
  logic        h_we;
  logic [4:0]  h_wr;
  logic [31:0] h_wd;
`endif

  int checks = 0;
  int errors = 0;

  logic        m_valid, m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd, m_cnt;

  mem_wb_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .Valid2(Valid2), .RegWrite2(RegWrite2), .MemtoReg2(MemtoReg2),
    .Link2(Link2), .WriteReg2(WriteReg2),
    .ALUResult_out(ALUResult_out), .ReadData(ReadData),
    .PCPlus8_2(PCPlus8_2),
    .RegWrite3(RegWrite3), .WriteReg3(WriteReg3),
    .WriteData3(WriteData3), .Valid3(Valid3),
    .InstRetired(InstRetired)
`ifdef WB_HISTORY_EN
    , .RegWrite4(RegWrite4), .WriteReg4(WriteReg4),
    .WriteData4(WriteData4)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic model_clear();
    m_valid = 0; m_we = 0; m_wr = 0; m_wd = 0; m_cnt = 0;
`ifdef WB_HISTORY_EN
    h_we = 0; h_wr = 0; h_wd = 0;
`endif
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic mr, input logic lk,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc);
    Stall = 0; Flush = 0;
    Valid2 = v; RegWrite2 = we; MemtoReg2 = mr; Link2 = lk;
    WriteReg2 = wr; ALUResult_out = alu; ReadData = rd; PCPlus8_2 = pc;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Advance one edge; model follows the documented per-edge rules.
  task automatic step();
    @(posedge Clk);
    if (m_valid && !Stall) m_cnt = m_cnt + 32'd1;
`ifdef WB_HISTORY_EN
    if (!Stall) begin h_we = m_we; h_wr = m_wr; h_wd = m_wd; end
`endif
    if (Flush) begin
      m_valid = 0; m_we = 0; m_wr = 0; m_wd = 0;
    end else if (!Stall) begin
      m_valid = Valid2;
      m_we = RegWrite2 && Valid2 && (WriteReg2 != 0);
      m_wr = WriteReg2;
      m_wd = Link2 ? PCPlus8_2 : (MemtoReg2 ? ReadData : ALUResult_out);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1; bubble();
    model_clear();
    #2;
    Reset = 0;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b %h %h %b %h want all zero",
               RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
    end
  endtask

  task automatic test_alu();
    drive(1, 1, 0, 0, 5'd5, 32'h1234, 32'hAAAA_0000, 32'h8);
    step();
    checks++;
    if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !==
        {1'b1, 5'd5, 32'h1234, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL alu_op got we=%b wr=%0d wd=%h v=%b cnt=%0d want 1 5 1234 1 0",
               RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
    end
    bubble();
    step();
    checks++;
    if (InstRetired !== 32'd1 || Valid3 !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire got cnt=%0d v=%b want 1 0", InstRetired, Valid3);
    end
  endtask

  task automatic test_load_link();
    drive(1, 1, 1, 0, 5'd7, 32'h1111, 32'hDEAD_BEEF, 32'h40);
    step();
    checks++;
    if (WriteData3 !== 32'hDEAD_BEEF || RegWrite3 !== 1'b1) begin
      errors++;
      $display("FAIL load_data got %h we=%b want deadbeef 1", WriteData3, RegWrite3);
    end
    drive(1, 1, 1, 1, 5'd31, 32'h2222, 32'h3333, 32'h40);
    step();
    checks++;
    if (WriteData3 !== 32'h40 || WriteReg3 !== 5'd31 || InstRetired !== 32'd2) begin
      errors++;
      $display("FAIL link_data got wd=%h wr=%0d cnt=%0d want 40 31 2",
               WriteData3, WriteReg3, InstRetired);
    end
    bubble();
    step();
  endtask

  task automatic test_r0();
    drive(1, 1, 0, 0, 5'd0, 32'd7, 32'h5, 32'h6);
    step();
    checks++;
    if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !==
        {1'b0, 5'd0, 32'd7, 1'b1, 32'd3}) begin
      errors++;
      $display("FAIL r0_suppress got we=%b wr=%0d wd=%h v=%b cnt=%0d want 0 0 7 1 3",
               RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
    end
    bubble();
    step();
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 1, 0, 5'd9, 32'h0, 32'hCAFE_0001, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'($urandom_range(1, 31)), $urandom, $urandom, $urandom);
      Stall = 1;
      step();
      checks++;
      if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !==
          {1'b1, 5'd9, 32'hCAFE_0001, 1'b1, 32'd4}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got we=%b wr=%0d wd=%h v=%b cnt=%0d want 1 9 cafe0001 1 4",
                 i, RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
      end
    end
    Stall = 1; Flush = 1;
    step();
    checks++;
    if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 32'd4}) begin
      errors++;
      $display("FAIL stall_flush got we=%b wr=%0d wd=%h v=%b cnt=%0d want 0 0 0 0 4",
               RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
    end
    bubble();
    step();
    checks++;
    if (InstRetired !== 32'd4) begin
      errors++;
      $display("FAIL flushed_no_retire got %0d want 4", InstRetired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            5'($urandom), $urandom, $urandom, $urandom);
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !==
          {m_we, m_wr, m_wd, m_valid, m_cnt}) begin
        errors++;
        $display("FAIL random[%0d] got we=%b wr=%0d wd=%h v=%b cnt=%0d want %b %0d %h %b %0d",
                 i, RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired,
                 m_we, m_wr, m_wd, m_valid, m_cnt);
      end
`ifdef WB_HISTORY_EN
      checks++;
      if ({RegWrite4, WriteReg4, WriteData4} !== {h_we, h_wr, h_wd}) begin
        errors++;
        $display("FAIL random_hist[%0d] got %b %0d %h want %b %0d %h",
                 i, RegWrite4, WriteReg4, WriteData4, h_we, h_wr, h_wd);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    drive(1, 1, 0, 0, 5'd2, 32'h99, 32'h0, 32'h0);
    step();
    Stall = 1;
    force dut.InstRetired = 32'hFFFF_FFFF;
    #1;
    release dut.InstRetired;
    m_cnt = 32'hFFFF_FFFF;
    step();
    Stall = 0;
    bubble();
    step();
    checks++;
    if (InstRetired !== 32'd0 || m_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap got %h want 00000000", InstRetired);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 0, 5'd12, 32'hABCD, 32'h0, 32'h0);
    step();
    Stall = 1; Flush = 1;
    #2;
    Reset = 1;
    #1;
    checks++;
    if ({RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired} !== '0) begin
      errors++;
      $display("FAIL async_reset got we=%b wr=%0d wd=%h v=%b cnt=%0d want all zero",
               RegWrite3, WriteReg3, WriteData3, Valid3, InstRetired);
    end
    model_clear();
    Reset = 0;
    drive(1, 1, 0, 0, 5'd12, 32'h77, 32'h0, 32'h0);
    step();
    bubble();
    step();
    checks++;
    if (InstRetired !== 32'd1) begin
      errors++;
      $display("FAIL restart_count got %0d want 1", InstRetired);
    end
  endtask

`ifdef WB_HISTORY_EN
  task automatic test_history();
    drive(1, 1, 0, 0, 5'd3, 32'd1, 32'h0, 32'h0);
    step();
    drive(1, 1, 0, 0, 5'd3, 32'd2, 32'h0, 32'h0);
    step();
    checks++;
    if (WriteData4 !== 32'd1 || WriteData3 !== 32'd2 ||
        RegWrite4 !== 1'b1 || WriteReg4 !== 5'd3) begin
      errors++;
      $display("FAIL history got wd4=%h wd3=%h we4=%b wr4=%0d want 1 2 1 3",
               WriteData4, WriteData3, RegWrite4, WriteReg4);
    end
    drive(1, 1, 0, 0, 5'd4, 32'd9, 32'h0, 32'h0);
    Stall = 1;
    step();
    checks++;
    if (WriteData4 !== 32'd1 || WriteData3 !== 32'd2) begin
      errors++;
      $display("FAIL history_stall got wd4=%h wd3=%h want 1 2", WriteData4, WriteData3);
    end
  endtask
`endif

  initial begin
    Reset = 1;
    bubble();
    model_clear();
    #3;
    test_reset();
    #4;
    Reset = 0;
    test_alu();
    test_load_link();
    test_r0();
    test_stall_flush();
    do_reset();
    test_random();
    test_wrap();
    test_async_reset();
`ifdef WB_HISTORY_EN
    do_reset();
    test_history();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline stage of the five-stage CPU: registers the outputs of the memory stage, selects the write-back value (ALU result, load data or link address) and drives the register-file write port. It also exports the registered destination for WB→EX forwarding and keeps a retired-instruction counter. It sits directly downstream of the memory stage and upstream of the register file and the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold the stage contents; no retire
- Flush  in  1  replace incoming instruction with a bubble
- Valid2  in  1  memory-stage slot holds a real instruction
- RegWrite2  in  1  instruction writes a register
- MemtoReg2  in  1  write-back selects load data
- Link2  in  1  write-back selects link address (jal/jalr)
- WriteReg2  in  REG_AW  destination register
- ALUResult_out  in  DATA_W  ALU result from the memory stage
- ReadData  in  DATA_W  load data from the data memory
- PCPlus8_2  in  DATA_W  link address
- RegWrite3  out  1  register-file write enable
- WriteReg3  out  REG_AW  register-file write address
- WriteData3  out  DATA_W  register-file write data
- Valid3  out  1  WB slot holds a real instruction
- InstRetired  out  32  count of retired instructions

## Operation
- Write-back select, evaluated on stage inputs before registering: Link2 → PCPlus8_2; else MemtoReg2 → ReadData; else ALUResult_out. Link2 wins if both selects are set.
- RegWrite3 = registered (RegWrite2 & Valid2) & (WriteReg2 != 0); writes to r0 are suppressed and WriteData3 still updates.
- Per rising edge, priority: Flush > Stall > normal.
  - Flush: Valid3 ← 0, RegWrite3 ← 0; WriteReg3/WriteData3 ← 0.
  - Stall (no Flush): every register holds; RegWrite3 stays as held. The register file is idempotent, so a repeated write is harmless.
  - Normal: all outputs load from the stage inputs.
- Retire counter: increments by 1 on each edge where Valid3 = 1 and Stall = 0. A bubble does not count, and neither does a stalled repeat. It wraps 0xFFFFFFFF → 0 silently.
- Reset: all outputs are 0 (Valid3, RegWrite3, WriteReg3, WriteData3, InstRetired, and history registers when compiled in).

## Timing
- Latency 1 cycle: inputs sampled on edge N appear on the outputs after edge N and are written to the register file on edge N+1.
- Reset is asynchronous on assertion and takes effect immediately. Deassertion is synchronised externally, and the first active edge is the first edge with Reset low.
- Reset mid-stall or mid-flush: Reset wins. Outputs clear, and the counter restarts at 0.
- Stall and Flush on the same edge: flush behaviour; the counter does not increment, because Stall is high.
- Outputs are purely registered; no combinational path from inputs to outputs, so forwarding consumers see a clean registered value.

## Configuration
- Macro WB_HISTORY_EN.
- Defined: adds a second register set (RegWrite4, WriteReg4[REG_AW-1:0], WriteData4[DATA_W-1:0]) as extra outputs.
  - This set loads the current WB-slot values on every non-stalled edge, flushed or not, and holds on Stall.
  - The forwarding unit uses it to cover a register file that writes on the rising edge and reads before write.
  - Reset value is 0.
- Undefined: these ports and registers do not exist, and the behaviour above is unchanged.

## Test plan
- ALU op: Valid2=1, RegWrite2=1, WriteReg2=5, ALUResult_out=0x0000_1234, MemtoReg2=0 → after 1 edge RegWrite3=1, WriteReg3=5, WriteData3=0x1234, Valid3=1; next non-stalled edge InstRetired=1.
- Load and link: MemtoReg2=1, ReadData=0xDEAD_BEEF → WriteData3=0xDEADBEEF. Then Link2=1, MemtoReg2=1, PCPlus8_2=0x40 → WriteData3=0x40.
- r0 suppression: RegWrite2=1, WriteReg2=0, ALUResult_out=7 → RegWrite3=0, WriteData3=7, Valid3=1.
- Stall/flush: load op, then Stall=1 for 3 edges with new inputs → outputs unchanged and counter frozen. Then Stall=1 and Flush=1 → Valid3=0, RegWrite3=0, counter unchanged.
- Wrap and reset: force 0xFFFF_FFFF retires (or preload via a bench hook) → counter 0 after next retire. Assert Reset between edges → all outputs 0 immediately, without waiting for Clk.
- WB_HISTORY_EN: two back-to-back writes to r3 (values 1, 2) → after second edge WriteData4=1, WriteData3=2; with Stall, both hold.
